// File: rtl/alu_seq.sv
// alu_seq: clocked, parametrised ALU with a Start/Busy/Done handshake.
// WIDTH-bit unsigned operands and a 2*WIDTH-bit registered result/accumulator.
// Single-cycle ops complete at the edge that accepts Start. MUL is a
// shift-add multiply that takes WIDTH cycles.
// Optional feature macro: ALU_SEQ_MUL_EN. When it is defined, the multiplier
// datapath and the MUL state are built. When it is not defined, Function=100
// behaves like the reserved code and Busy is tied low.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           Function,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   ALUout
);

  localparam int RW = 2 * WIDTH;

  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_ORR  = 3'b001,
    FN_ANDR = 3'b010,
    FN_CAT  = 3'b011,
    FN_MUL  = 3'b100,
    FN_ACC  = 3'b101,
    FN_SUB  = 3'b110,
    FN_RSV  = 3'b111
  } func_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  state_e         state;
  state_e         state_nxt;
  logic           single_op;   // accepted Start that completes at this edge
  logic [RW-1:0]  op_result;   // result of the single-cycle op on live inputs
  logic [RW-1:0]  alu_q;
  logic           done_q;
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_diff;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic           mul_start;   // accepted Start with Function=MUL
  logic           mul_last;    // edge that folds in the top multiplier bit
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]  count;
  logic [RW-1:0]  pp;
  logic [RW-1:0]  pp_sum;
`endif

  // State register; Reset returns to IDLE and aborts any multiply.
  always_ff @(posedge Clock) begin
    // NOTE: Reset is tested inside the clocked block, so it is synchronous.
    // State is updated with non-blocking assignments so that every flop
    // samples the values that were present before the edge.
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: Every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_nxt = state;
    single_op = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
    mul_last  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef ALU_SEQ_MUL_EN
          if (func_e'(Function) == FN_MUL) begin
            mul_start = 1'b1;
            state_nxt = MUL;
          end else begin
            single_op = 1'b1;
          end
`else
          single_op = 1'b1;
`endif
        end
      end
      MUL: begin
`ifdef ALU_SEQ_MUL_EN
        // Start is ignored here. The multiply runs to completion.
        if (count == CNT_LAST) begin
          mul_last  = 1'b1;
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle function results, computed from the live operands.
  always_comb begin
    add_sum  = {1'b0, A} + {1'b0, B};
    sub_diff = {1'b0, A} - {1'b0, B};
    op_result = '0;
    case (func_e'(Function))
      FN_ADD:  op_result = {{(WIDTH-1){1'b0}}, add_sum};
      FN_ORR:  op_result = {{(RW-1){1'b0}}, |{A, B}};
      FN_ANDR: op_result = {{(RW-1){1'b0}}, &{A, B}};
      FN_CAT:  op_result = {A, B};
      FN_ACC:  op_result = alu_q + {{WIDTH{1'b0}}, A};
      // The borrow bit sub_diff[WIDTH] is the sign of the true difference.
      FN_SUB:  op_result = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
      // MUL never reaches here when the multiplier is built. Without it,
      // MUL acts like the reserved code and clears the result.
      FN_MUL,
      FN_RSV:  op_result = '0;
      default: op_result = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Partial product after folding in the current multiplier bit.
  always_comb begin
    pp_sum = pp;
    if (b_q[count]) pp_sum = pp + ({{WIDTH{1'b0}}, a_q} << count);
  end

  // Multiplier operand latch, bit counter and partial-product accumulator.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      count <= '0;
      pp    <= '0;
    end else if (mul_start) begin
      a_q   <= A;
      b_q   <= B;
      count <= '0;
      pp    <= '0;
    end else if (state == MUL) begin
      pp    <= pp_sum;
      count <= count + 1'b1;
    end
  end
`endif

  // Result register and Done pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      alu_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (single_op) begin
        alu_q  <= op_result;
        done_q <= 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      if (mul_last) begin
        alu_q  <= pp_sum;
        done_q <= 1'b1;
      end
`endif
    end
  end

`ifdef ALU_SEQ_MUL_EN
  assign Busy = (state == MUL);
`else
  assign Busy = 1'b0;
`endif
  assign Done   = done_q;
  assign ALUout = alu_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4): a table of single-cycle vectors
// plus hand-written sequences for accumulate, reset and multiply corner cases.
module tb_alu_seq;

  localparam int WIDTH = 4;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [2:0]       Function = 3'b000;
  logic             Busy;
  logic             Done;
  logic [2*WIDTH-1:0] ALUout;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Function (Function),
    .Busy     (Busy),
    .Done     (Done),
    .ALUout   (ALUout)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0] fn;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_op(input logic [2:0] fn, input logic [3:0] a, input logic [3:0] b);
    Start = 1'b1; Function = fn; A = a; B = b;
    step();
    Start = 1'b0;
  endtask

  initial begin
    int acc_exp;
    int done_cnt;

    vecs[0]  = '{3'b000, 4'hF, 4'h1, 8'h10};  // ADD with carry-out
    vecs[1]  = '{3'b110, 4'h3, 4'h5, 8'hFE};  // SUB negative
    vecs[2]  = '{3'b011, 4'hA, 4'h5, 8'hA5};  // CAT
    vecs[3]  = '{3'b001, 4'h0, 4'h0, 8'h00};  // ORR all zero
    vecs[4]  = '{3'b010, 4'hF, 4'hF, 8'h01};  // ANDR all ones
    vecs[5]  = '{3'b010, 4'hF, 4'hE, 8'h00};  // ANDR one zero bit
    vecs[6]  = '{3'b000, 4'h7, 4'h8, 8'h0F};  // ADD no carry
    vecs[7]  = '{3'b110, 4'h9, 4'h2, 8'h07};  // SUB positive
    vecs[8]  = '{3'b001, 4'h0, 4'h4, 8'h01};  // ORR bit in B
    vecs[9]  = '{3'b001, 4'h8, 4'h0, 8'h01};  // ORR bit in A
    vecs[10] = '{3'b111, 4'hF, 4'hF, 8'h00};  // reserved clears
    vecs[11] = '{3'b110, 4'h0, 4'hF, 8'hF1};  // SUB 0-15 = -15

    // Reset state.
    step(); step();
    check("reset_aluout", 32'(ALUout), 32'h0);
    check("reset_done",   32'(Done),   32'h0);
    check("reset_busy",   32'(Busy),   32'h0);
    Reset = 1'b0;
    step();
    check("idle_done", 32'(Done), 32'h0);

    // Table of single-cycle operations: result at the accepting edge, then held.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].fn, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_done", i),   32'(Done),   32'h1);
      check($sformatf("vec%0d_aluout", i), 32'(ALUout), 32'(vecs[i].exp));
      check($sformatf("vec%0d_busy", i),   32'(Busy),   32'h0);
      step();
      check($sformatf("vec%0d_done_low", i), 32'(Done),   32'h0);
      check($sformatf("vec%0d_hold", i),     32'(ALUout), 32'(vecs[i].exp));
    end

    // ACC held for 18 cycles after reset: one accumulate and Done per cycle.
    Reset = 1'b1; step(); Reset = 1'b0;
    acc_exp = 0; done_cnt = 0;
    Start = 1'b1; Function = 3'b101; A = 4'hF; B = 4'h0;
    for (int i = 0; i < 18; i++) begin
      step();
      acc_exp = (acc_exp + 15) % 256;
      if (Done === 1'b1) done_cnt++;
      check($sformatf("acc%0d", i), 32'(ALUout), 32'(acc_exp));
    end
    Start = 1'b0;
    check("acc_final", 32'(ALUout), 32'h0E);
    check("acc_done_count", 32'(done_cnt), 32'd18);
    step();
    check("acc_done_low", 32'(Done), 32'h0);
    check("acc_hold", 32'(ALUout), 32'h0E);

    // Reset and Start at the same edge: reset wins, nothing executes.
    run_op(3'b000, 4'hF, 4'h1);
    check("pre_rst_aluout", 32'(ALUout), 32'h10);
    Start = 1'b1; Function = 3'b000; A = 4'h1; B = 4'h1; Reset = 1'b1;
    step();
    Start = 1'b0; Reset = 1'b0;
    check("rst_start_aluout", 32'(ALUout), 32'h0);
    check("rst_start_done",   32'(Done),   32'h0);
    step();
    check("rst_start_done2",  32'(Done),   32'h0);
    check("rst_start_hold",   32'(ALUout), 32'h0);

`ifdef ALU_SEQ_MUL_EN
    // MUL F*F: Busy for 4 cycles, Start/ADD and operand changes are ignored.
    run_op(3'b011, 4'h3, 4'hC);
    check("pre_mul_aluout", 32'(ALUout), 32'h3C);
    run_op(3'b100, 4'hF, 4'hF);
    Start = 1'b1; Function = 3'b000;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mul_busy%0d", i),   32'(Busy),   32'h1);
      check($sformatf("mul_done%0d", i),   32'(Done),   32'h0);
      check($sformatf("mul_aluout%0d", i), 32'(ALUout), 32'h3C);
      A = 4'(i); B = 4'(i + 1);
      step();
    end
    Start = 1'b0;
    check("mul_done",   32'(Done),   32'h1);
    check("mul_busy",   32'(Busy),   32'h0);
    check("mul_result", 32'(ALUout), 32'hE1);
    // Start on the Done cycle is accepted normally.
    run_op(3'b000, 4'h2, 4'h3);
    check("done_cycle_start_done",   32'(Done),   32'h1);
    check("done_cycle_start_aluout", 32'(ALUout), 32'h05);
    step();
    check("done_cycle_start_low", 32'(Done), 32'h0);

    // MUL 7*3 aborted by reset: result cleared, no Done afterwards.
    run_op(3'b100, 4'h7, 4'h3);
    check("abort_busy", 32'(Busy), 32'h1);
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("abort_aluout", 32'(ALUout), 32'h0);
    check("abort_busy_low", 32'(Busy), 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (Done !== 1'b0 || Busy !== 1'b0) done_cnt++;
      step();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_hold", 32'(ALUout), 32'h0);
`else
    // Without the multiplier, Function=100 acts as reserved.
    run_op(3'b000, 4'h1, 4'h1);
    check("pre_mul_aluout", 32'(ALUout), 32'h02);
    run_op(3'b100, 4'h3, 4'h3);
    check("nomul_done",   32'(Done),   32'h1);
    check("nomul_aluout", 32'(ALUout), 32'h00);
    check("nomul_busy",   32'(Busy),   32'h0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (Busy !== 1'b0 || Done !== 1'b0) done_cnt++;
    end
    check("nomul_quiet", 32'(done_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
